// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isa_pkg
// Description : Shared ISA definitions for the decode stage and register
//               file: opcodes, instruction field positions, datapath widths
//               and the decode FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package isa_pkg;

    localparam int INST_W = 24;
    localparam int PC_W   = 16;
    localparam int REG_W  = 16;
    localparam int NREGS  = 16;
    localparam int REG_AW = 4;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_BEQZ = 4'hD;
    localparam logic [OP_W-1:0] OP_JMP  = 4'hE;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    // Instruction field bit positions
    localparam int OP_MSB  = 23;
    localparam int OP_LSB  = 20;
    localparam int RD_MSB  = 19;
    localparam int RD_LSB  = 16;
    localparam int RS1_MSB = 15;
    localparam int RS1_LSB = 12;
    localparam int RS2_MSB = 11;
    localparam int RS2_LSB = 8;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_HALTED   = 2'd2
    } dec_state_e;

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_if
// Description : Bundle between fetch/writeback and the decode stage.
//               master : drives instruction and writeback, receives decode.
//               slave  : the decode stage itself.
//   instruction      fetched instruction word
//   wbEn/wbAddr/wbData  register writeback
//   pcWrEn/newPc     redirect request and target back to fetch
//   valid, opcode, rd, rs1Data, rs2Data, imm  decoded outputs to execute
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
    parameter int instSize = 24
);
    import isa_pkg::*;

    logic [instSize-1:0] instruction;
    logic                wbEn;
    logic [REG_AW-1:0]   wbAddr;
    logic [REG_W-1:0]    wbData;
    logic                pcWrEn;
    logic [instSize-9:0] newPc;
    logic                valid;
    logic [OP_W-1:0]     opcode;
    logic [REG_AW-1:0]   rd;
    logic [REG_W-1:0]    rs1Data;
    logic [REG_W-1:0]    rs2Data;
    logic [REG_W-1:0]    imm;

    modport master (
        output instruction, wbEn, wbAddr, wbData,
        input  pcWrEn, newPc, valid, opcode, rd, rs1Data, rs2Data, imm
    );

    modport slave (
        input  instruction, wbEn, wbAddr, wbData,
        output pcWrEn, newPc, valid, opcode, rd, rs1Data, rs2Data, imm
    );

endinterface
`default_nettype wire

// File: rtl/scalar_regfile.sv
`default_nettype none
// ============================================================================
// Module      : scalar_regfile
// Description : 16 x 16-bit register file, three combinational read ports,
//               one write port. R0 is hard-wired to zero. A write in flight
//               is forwarded to any read of the same (non-zero) index.
//   clk, rst            clock, synchronous active-high reset (clears all)
//   wr_en/wr_addr/wr_data  write port, stored on the rising edge
//   rd_addr[3]/rd_data[3]  read ports
// Revision    : 1.0 - initial release
// ============================================================================
module scalar_regfile
    import isa_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              wr_en,
    input  wire logic [REG_AW-1:0] wr_addr,
    input  wire logic [REG_W-1:0]  wr_data,
    input  wire logic [REG_AW-1:0] rd_addr [3],
    output logic      [REG_W-1:0]  rd_data [3]
);

    logic [REG_W-1:0] r_regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    generate
        for (genvar g = 0; g < 3; g++) begin : g_read
            assign rd_data[g] = (rd_addr[g] == '0)                ? '0      :
                                (wr_en && (wr_addr == rd_addr[g])) ? wr_data :
                                                                     r_regs[rd_addr[g]];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : IF/ID register, operand read, field decode and branch
//               resolution. JMP/BEQZ redirect fetch; the one wrong-path
//               instruction behind a taken branch is squashed; HALT stops
//               issue until reset.
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    decode_stage_if.slave (instruction/writeback in, decode out)
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import isa_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     reset,
    decode_stage_if.slave bus
);

    logic [INST_W-1:0] r_inst;
    logic              r_valid;
    logic [PC_W-1:0]   r_target;
    dec_state_e        r_state;
    dec_state_e        w_state_next;

    logic [OP_W-1:0]   w_op;
    logic [REG_AW-1:0] w_rd;
    logic [PC_W-1:0]   w_imm;
    logic [REG_AW-1:0] w_rd_addr [3];
    logic [REG_W-1:0]  w_rd_data [3];
    logic              w_live;
    logic              w_taken;
    logic              w_pc_wr;
    logic [PC_W-1:0]   w_new_pc;

    assign w_op  = r_inst[OP_MSB:OP_LSB];
    assign w_rd  = r_inst[RD_MSB:RD_LSB];
    assign w_imm = r_inst[IMM_MSB:IMM_LSB];

    // Port 2 reads R[rd] for the BEQZ zero test.
    assign w_rd_addr[0] = r_inst[RS1_MSB:RS1_LSB];
    assign w_rd_addr[1] = r_inst[RS2_MSB:RS2_LSB];
    assign w_rd_addr[2] = w_rd;

    scalar_regfile u_regfile (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (bus.wbEn),
        .wr_addr (bus.wbAddr),
        .wr_data (bus.wbData),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    // Only an instruction issued in RUN may branch or halt; the wrong-path
    // slot (REDIRECT) and anything after HALT are inert.
    assign w_live  = r_valid && (r_state == ST_RUN);
    assign w_taken = w_live && ((w_op == OP_JMP) ||
                                ((w_op == OP_BEQZ) && (w_rd_data[2] == '0)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_valid  <= 1'b0;
            r_inst   <= '0;
            r_target <= '0;
        end else begin
            r_state <= w_state_next;
            r_valid <= 1'b1;
            r_inst  <= bus.instruction;
            if (w_taken) begin
                r_target <= w_imm;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_wr      = 1'b0;
        w_new_pc     = w_imm;
        case (r_state)
            ST_RUN: begin
                if (w_taken) begin
                    w_pc_wr      = 1'b1;
                    w_state_next = ST_REDIRECT;
                end else if (w_live && (w_op == OP_HALT)) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_REDIRECT: begin
                // Fetch muxes newPc one cycle after pcWrEn, so hold the target.
                w_new_pc     = r_target;
                w_state_next = ST_RUN;
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    assign bus.pcWrEn  = w_pc_wr;
    assign bus.newPc   = w_new_pc;
    assign bus.valid   = w_live;
    assign bus.opcode  = w_op;
    assign bus.rd      = w_rd;
    assign bus.rs1Data = w_rd_data[0];
    assign bus.rs2Data = w_rd_data[1];
    assign bus.imm     = w_imm;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage: reset state, operand
//               read and bypass, R0, JMP/BEQZ redirect and squash, HALT,
//               reset out of REDIRECT and HALTED.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    decode_stage_if #(.instSize(24)) bus ();

    decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] inst;
        logic        wb_en;
        logic [3:0]  wb_addr;
        logic [15:0] wb_data;
        logic        exp_valid;
        logic        exp_pcwr;
        logic [15:0] exp_newpc;
        logic [15:0] exp_rs1;
        logic [15:0] exp_rs2;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive instruction before the edge; apply writeback just after the edge
    // so it is visible to this cycle's reads and stored at the next edge.
    task automatic step(input logic [23:0] inst, input logic we,
                        input logic [3:0] wa, input logic [15:0] wd);
        @(negedge clk);
        bus.instruction = inst;
        @(posedge clk);
        #1;
        bus.wbEn   = we;
        bus.wbAddr = wa;
        bus.wbData = wd;
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic v, input logic p,
                             input logic [15:0] np);
        check({tag, " valid"},  {31'd0, bus.valid},  {31'd0, v});
        check({tag, " pcWrEn"}, {31'd0, bus.pcWrEn}, {31'd0, p});
        check({tag, " newPc"},  {16'd0, bus.newPc},  {16'd0, np});
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //            inst        we  wa    wd        v  p  newPc     rs1       rs2
        vecs[0]  = '{24'h000000, 1'b1, 4'd3, 16'h1234, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{24'h143300, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 16'h3300, 16'h1234, 16'h1234};
        vecs[2]  = '{24'h143300, 1'b1, 4'd3, 16'hBEEF, 1'b1, 1'b0, 16'h3300, 16'hBEEF, 16'hBEEF};
        vecs[3]  = '{24'h143500, 1'b1, 4'd5, 16'h0007, 1'b1, 1'b0, 16'h3500, 16'hBEEF, 16'h0007};
        vecs[4]  = '{24'h100000, 1'b1, 4'd0, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        vecs[5]  = '{24'h100000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        vecs[6]  = '{24'hD50080, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 16'h0080, 16'h0000, 16'h0000};
        vecs[7]  = '{24'h125000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 16'h5000, 16'h0007, 16'h0000};
        vecs[8]  = '{24'hE00040, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h0000, 16'h0000};
        vecs[9]  = '{24'hF00000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000};
        vecs[10] = '{24'h133500, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 16'h3500, 16'hBEEF, 16'h0007};
        vecs[11] = '{24'h000000, 1'b1, 4'd5, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        vecs[12] = '{24'hD50123, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 16'h0123, 16'h0000, 16'h0000};
        vecs[13] = '{24'hE00777, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0123, 16'h0000, 16'h0000};
        vecs[14] = '{24'hE00200, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 16'h0200, 16'h0000, 16'h0000};
        vecs[15] = '{24'h100000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'h0000};
        vecs[16] = '{24'h100000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000};

        // Reset held two cycles with a NOP stream
        reset           = 1'b1;
        bus.instruction = 24'h000000;
        bus.wbEn        = 1'b0;
        bus.wbAddr      = 4'd0;
        bus.wbData      = 16'h0000;
        repeat (2) @(posedge clk);
        #2;
        check_ctl("reset", 1'b0, 1'b0, 16'h0000);
        check("reset opcode", {28'd0, bus.opcode}, 32'd0);
        check("reset rs1Data", {16'd0, bus.rs1Data}, 32'd0);
        check("reset imm", {16'd0, bus.imm}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("pre-edge valid", {31'd0, bus.valid}, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].inst, vecs[i].wb_en, vecs[i].wb_addr, vecs[i].wb_data);
            check_ctl($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_pcwr, vecs[i].exp_newpc);
            check($sformatf("v%0d rs1Data", i), {16'd0, bus.rs1Data}, {16'd0, vecs[i].exp_rs1});
            check($sformatf("v%0d rs2Data", i), {16'd0, bus.rs2Data}, {16'd0, vecs[i].exp_rs2});
            check($sformatf("v%0d opcode", i), {28'd0, bus.opcode}, {28'd0, vecs[i].inst[23:20]});
            check($sformatf("v%0d rd", i), {28'd0, bus.rd}, {28'd0, vecs[i].inst[19:16]});
            check($sformatf("v%0d imm", i), {16'd0, bus.imm}, {16'd0, vecs[i].inst[15:0]});
        end

        // HALT issues once, then nothing issues whatever arrives
        step(24'hF00000, 1'b0, 4'd0, 16'h0000);
        check_ctl("halt issue", 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step(24'hE00040, 1'b0, 4'd0, 16'h0000);
            check_ctl($sformatf("halted%0d", i), 1'b0, 1'b0, 16'h0040);
        end

        // Reset out of HALTED, then normal issue
        reset = 1'b1;
        step(24'hE00040, 1'b0, 4'd0, 16'h0000);
        check_ctl("halt reset", 1'b0, 1'b0, 16'h0000);
        reset = 1'b0;
        step(24'h133500, 1'b0, 4'd0, 16'h0000);
        check_ctl("after halt reset", 1'b1, 1'b0, 16'h3500);
        check("regs cleared rs1", {16'd0, bus.rs1Data}, 32'd0);

        // Reset while in REDIRECT drops the pending redirect
        step(24'hE00050, 1'b0, 4'd0, 16'h0000);
        check_ctl("jmp2", 1'b1, 1'b1, 16'h0050);
        step(24'h100000, 1'b0, 4'd0, 16'h0000);
        check_ctl("jmp2 squash", 1'b0, 1'b0, 16'h0050);
        reset = 1'b1;
        step(24'h133500, 1'b0, 4'd0, 16'h0000);
        check_ctl("redirect reset", 1'b0, 1'b0, 16'h0000);
        reset = 1'b0;
        step(24'h133500, 1'b0, 4'd0, 16'h0000);
        check_ctl("after redirect reset", 1'b1, 1'b0, 16'h3500);
        step(24'h100000, 1'b0, 4'd0, 16'h0000);
        check_ctl("resume", 1'b1, 1'b0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
